// File: rtl/hazard_stall_ctrl.sv
// Pipeline hold/flush/bubble/freeze sequencing for the 5-stage core, with saturating statistics.
// Optional build macro FORWARDING_EN: with it only load-use stalls; without it any EXE/MEM match stalls.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             hold_pc,
  output logic             hold_ifid,
  output logic             flush_ifid,
  output logic             bubble_idexe,
  output logic             freeze_all,
  output logic             mem_timeout_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StRun = 2'd0, StMemWait = 2'd1, StError = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic freeze, hold, flush, bubble, hold_if;
  logic exe_hit, raw_stall;

  function automatic logic reg_match(input logic [4:0] dest, input logic wb_en,
                                     input logic [4:0] r);
    return wb_en && (dest != 5'd0) && (dest == r);
  endfunction

  assign exe_hit = reg_match(exe_dest, exe_wb_en, id_src1) ||
                   (id_two_src && reg_match(exe_dest, exe_wb_en, id_src2));

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet available.
  logic unused_mem;
  assign unused_mem = ^{mem_dest, mem_wb_en};
  assign raw_stall  = exe_mem_read && exe_hit;
`else
  logic mem_hit;
  logic unused_read;
  assign unused_read = exe_mem_read;
  assign mem_hit     = reg_match(mem_dest, mem_wb_en, id_src1) ||
                       (id_two_src && reg_match(mem_dest, mem_wb_en, id_src2));
  assign raw_stall   = exe_hit || mem_hit;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    freeze  = 1'b0;
    hold    = 1'b0;
    hold_if = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_req && !mem_ready) begin
          freeze  = 1'b1;
          state_d = StMemWait;
          wait_d  = '0;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
        end else begin
          freeze = 1'b1;
          if (wait_q == TO_W'(MEM_TIMEOUT - 1)) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      StError: freeze = 1'b1;
      default: state_d = StRun;
    endcase

    // Frozen pipeline ignores branches and hazards; EXE re-presents them on release.
    if (!freeze) begin
      if (branch_taken) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (raw_stall) begin
        hold    = 1'b1;
        hold_if = 1'b1;
        bubble  = 1'b1;
      end
    end

    stall_d = (hold && stall_q != {CNT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;
    flush_d = (flush && flush_q != {CNT_W{1'b1}}) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Controls are forced inactive while reset is asserted.
  assign hold_pc         = reset && hold;
  assign hold_ifid       = reset && hold_if;
  assign flush_ifid      = reset && flush;
  assign bubble_idexe    = reset && bubble;
  assign freeze_all      = reset && freeze;
  assign mem_timeout_err = err_q;
  assign state           = state_q;
  assign stall_cnt       = stall_q;
  assign flush_cnt       = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, corner sequences, random vs. model.
module tb_hazard_stall_ctrl;
  localparam int unsigned TMO = 4;
  localparam int unsigned TOW = 3;
  localparam int unsigned CW  = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [4:0] C_NONE = 5'b00000, C_STALL = 5'b11010, C_BR = 5'b00110,
                         C_FRZ = 5'b00001;

  logic clock = 1'b0, reset = 1'b0;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, mem_req, mem_ready, branch_taken;
  logic hold_pc, hold_ifid, flush_ifid, bubble_idexe, freeze_all, mem_timeout_err;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(TOW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .flush_ifid(flush_ifid),
    .bubble_idexe(bubble_idexe), .freeze_all(freeze_all), .mem_timeout_err(mem_timeout_err),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0;
  int m_mode, m_waited, m_err, m_stall, m_flush;

  typedef struct {
    string      name;
    logic [4:0] s1, s2, ed, md;
    logic       two, ewb, erd, mwb, req, rdy, br;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mk(input string nm, input logic [4:0] s1, input logic [4:0] s2,
                              input logic two, input logic [4:0] ed, input logic ewb,
                              input logic erd, input logic [4:0] md, input logic mwb,
                              input logic req, input logic rdy, input logic br,
                              input logic [4:0] exp);
    vec_t v;
    v.name = nm; v.s1 = s1; v.s2 = s2; v.two = two; v.ed = ed; v.ewb = ewb; v.erd = erd;
    v.md = md; v.mwb = mwb; v.req = req; v.rdy = rdy; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two; exe_dest = v.ed; exe_wb_en = v.ewb;
    exe_mem_read = v.erd; mem_dest = v.md; mem_wb_en = v.mwb; mem_req = v.req;
    mem_ready = v.rdy; branch_taken = v.br;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] ctrl();
    return {hold_pc, hold_ifid, flush_ifid, bubble_idexe, freeze_all};
  endfunction

  // Reference: controls derived from the listed rules (readers vs. producers sets).
  function automatic logic [4:0] model_ctrl();
    logic [4:0] reads[$];
    logic [4:0] prods[$];
    bit stall = 0;
    if (!reset) return C_NONE;
    if ((m_mode == 0 && mem_req && !mem_ready) || (m_mode == 1 && !mem_ready) || m_mode == 2)
      return C_FRZ;
    if (branch_taken) return C_BR;
    reads.push_back(id_src1);
    if (id_two_src) reads.push_back(id_src2);
    if (exe_wb_en && exe_dest != 0 && (!FWD || exe_mem_read)) prods.push_back(exe_dest);
    if (!FWD && mem_wb_en && mem_dest != 0) prods.push_back(mem_dest);
    foreach (reads[i]) foreach (prods[j]) if (reads[i] == prods[j]) stall = 1;
    return stall ? C_STALL : C_NONE;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    logic [4:0] c;
    c = model_ctrl();
    if (!reset) return;
    if (c[4]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    if (c[2]) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
    if (m_mode == 0) begin
      if (mem_req && !mem_ready) begin m_mode = 1; m_waited = 0; end
    end else if (m_mode == 1) begin
      if (mem_ready) m_mode = 0;
      else begin
        m_waited++;
        if (m_waited == TMO) begin m_mode = 2; m_err = 1; end
      end
    end
  endtask

  task automatic check_all(input string nm);
    check({nm, " ctrl"}, ctrl(), model_ctrl());
    check({nm, " state"}, state, m_mode);
    check({nm, " err"}, mem_timeout_err, m_err);
    check({nm, " stall_cnt"}, stall_cnt, m_stall);
    check({nm, " flush_cnt"}, flush_cnt, m_flush);
  endtask

  // Called at a falling edge with inputs already set; leaves at the next falling edge.
  task automatic cycle(input string nm);
    #2;
    check_all(nm);
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst ctrl", ctrl(), C_NONE);
    check("rst state", state, 0);
    check("rst counters", {stall_cnt, flush_cnt}, 0);
    check("rst err", mem_timeout_err, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  vec_t idle, lu, lu_br;

  initial begin
    idle  = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE);
    lu    = mk("loaduse", 3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, C_STALL);
    lu_br = mk("br+haz", 3, 0, 0, 3, 1, 1, 0, 0, 0, 1, 1, C_BR);
    vecs[0]  = idle;
    vecs[1]  = lu;
    vecs[2]  = mk("dest0", 3, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, C_NONE);
    vecs[3]  = mk("wb_off", 3, 0, 0, 3, 0, 1, 0, 0, 0, 1, 0, C_NONE);
    vecs[4]  = mk("src2_unused", 0, 3, 0, 3, 1, 1, 0, 0, 0, 1, 0, C_NONE);
    vecs[5]  = mk("src2_used", 0, 3, 1, 3, 1, 1, 0, 0, 0, 1, 0, C_STALL);
    vecs[6]  = lu_br;
    vecs[7]  = mk("exe_alu", 5, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, FWD ? C_NONE : C_STALL);
    vecs[8]  = mk("mem_match", 0, 7, 1, 0, 0, 0, 7, 1, 0, 1, 0, FWD ? C_NONE : C_STALL);
    vecs[9]  = mk("mem_dest0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_NONE);
    vecs[10] = mk("req_ready", 3, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, C_STALL);

    apply(idle);
    mem_req = 1'b1; mem_ready = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check({"vec ", vecs[i].name}, ctrl(), vecs[i].exp);
      if (i == 2) check("loaduse stall_cnt", stall_cnt, 1);
      cycle(vecs[i].name);
    end

    // Branch together with a hazard: flush wins, only flush_cnt moves.
    do_reset();
    apply(lu_br); cycle("br+haz");
    apply(idle); #1;
    check("br flush_cnt", flush_cnt, 1);
    check("br stall_cnt", stall_cnt, 0);
    cycle("br after");

    // Three frozen cycles, then release; the pending branch acts on the ready cycle.
    apply(lu_br);
    mem_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      check("wait ctrl", ctrl(), (k < 3) ? C_FRZ : C_BR);
      check("wait state", state, (k == 0) ? 0 : 1);
      cycle("wait");
    end
    apply(idle); #1;
    check("wait release state", state, 0);
    check("wait flush_cnt", flush_cnt, 2);
    cycle("wait done");

    // Reset pulled mid-wait clears outputs immediately.
    apply(idle); mem_req = 1'b1; mem_ready = 1'b0;
    repeat (3) cycle("pre-reset wait");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("midwait rst freeze", freeze_all, 0);
    check("midwait rst state", state, 0);
    @(negedge clock);
    reset = 1'b1;
    apply(idle); #1;
    check("post rst counters", {stall_cnt, flush_cnt}, 0);
    cycle("post rst");

    // Timeout: ready never arrives.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("tmo state", state, (k == 0) ? 0 : (k <= TMO) ? 1 : 2);
      cycle("tmo");
    end
    apply(lu_br);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("err state", state, 2);
      check("err flag", mem_timeout_err, 1);
      check("err ctrl", ctrl(), C_FRZ);
      cycle("err hold");
    end
    do_reset();

    // Counter saturation.
    apply(lu);
    repeat (SAT + 4) cycle("sat stall");
    apply(lu_br);
    repeat (SAT + 4) cycle("sat flush");
    apply(idle); #1;
    check("sat stall_cnt", stall_cnt, SAT);
    check("sat flush_cnt", flush_cnt, SAT);
    cycle("sat end");

    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      id_src1 = 5'($urandom_range(0, 3));
      id_src2 = 5'($urandom_range(0, 3));
      exe_dest = 5'($urandom_range(0, 3));
      mem_dest = 5'($urandom_range(0, 3));
      id_two_src = 1'($urandom); exe_wb_en = 1'($urandom); exe_mem_read = 1'($urandom);
      mem_wb_en = 1'($urandom); mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
